// File: rtl/cache_refill_controller.sv
// Refill and write-through controller for a direct-mapped 4-word-block cache.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_refill_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned OFFSET     = 2
`ifdef CACHE_STATS_EN
  ,
  parameter int unsigned STAT_WIDTH = 16
`endif
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  input  logic                  cache_miss,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_mem_rd,
  output logic                  cache_mem_wr,
  output logic                  cache_block_wr,
  output logic [DATA_WIDTH-1:0] cache_in0,
  output logic [DATA_WIDTH-1:0] cache_in1,
  output logic [DATA_WIDTH-1:0] cache_in2,
  output logic [DATA_WIDTH-1:0] cache_in3,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StWriteThru,
    StFetchReq,
    StFetchData,
    StRefill
  } state_e;

  state_e                state_q;
  logic [1:0]            beat_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic idle;
  logic rd_hit;
  logic rd_miss;
  logic wt_done;

  assign idle    = (state_q == StIdle);
  assign rd_hit  = idle & cpu_rd & ~cpu_wr & ~cache_miss;
  assign rd_miss = idle & cpu_rd & ~cpu_wr & cache_miss;
  assign wt_done = (state_q == StWriteThru) & mem_ack;

  always_comb begin
    cache_addr   = idle ? cpu_addr : addr_q;
    cache_mem_rd = rd_hit;
    // No allocate: a store that misses only goes to memory.
    cache_mem_wr = wt_done & ~cache_miss;
    case (state_q)
      StIdle:      cpu_stall = cpu_wr | (cpu_rd & cache_miss);
      StWriteThru: cpu_stall = ~mem_ack;
      default:     cpu_stall = 1'b1;
    endcase
    if (mem_wr_req) begin
      mem_addr  = addr_q;
      mem_wdata = data_q;
    end else if (mem_rd_req) begin
      mem_addr  = {addr_q[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
      mem_wdata = '0;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      beat_q         <= 2'd0;
      addr_q         <= '0;
      data_q         <= '0;
      cache_in0      <= '0;
      cache_in1      <= '0;
      cache_in2      <= '0;
      cache_in3      <= '0;
      mem_rd_req     <= 1'b0;
      mem_wr_req     <= 1'b0;
      cache_block_wr <= 1'b0;
    end else begin
      cache_block_wr <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cpu_wr) begin
            addr_q     <= cpu_addr;
            data_q     <= cpu_wdata;
            mem_wr_req <= 1'b1;
            state_q    <= StWriteThru;
          end else if (cpu_rd && cache_miss) begin
            addr_q     <= cpu_addr;
            mem_rd_req <= 1'b1;
            state_q    <= StFetchReq;
          end
        end
        StWriteThru: begin
          if (mem_ack) begin
            mem_wr_req <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StFetchReq: begin
          if (mem_ack) begin
            mem_rd_req <= 1'b0;
            beat_q     <= 2'd0;
            state_q    <= StFetchData;
          end
        end
        StFetchData: begin
          if (mem_rvalid) begin
            case (beat_q)
              2'd0:    cache_in0 <= mem_rdata;
              2'd1:    cache_in1 <= mem_rdata;
              2'd2:    cache_in2 <= mem_rdata;
              default: cache_in3 <= mem_rdata;
            endcase
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              cache_block_wr <= 1'b1;
              state_q        <= StRefill;
            end
          end
        end
        StRefill: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = rd_hit | (wt_done & ~cache_miss);
  assign miss_inc = rd_miss | (wt_done & cache_miss);

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != '1)) hit_count <= hit_count + STAT_WIDTH'(1);
      if (miss_inc && (miss_count != '1)) miss_count <= miss_count + STAT_WIDTH'(1);
    end
  end
`else
  // Statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller with a resident-block cache model
// and scoreboards for refilled lines and memory writes.
module tb_cache_refill_controller;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cache_miss;
  logic [AW-1:0] cache_addr;
  logic          cache_mem_rd, cache_mem_wr, cache_block_wr;
  logic [DW-1:0] cache_in0, cache_in1, cache_in2, cache_in3;
  logic          mem_rd_req, mem_wr_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack, mem_rvalid;
  logic [DW-1:0] mem_rdata;
`ifdef CACHE_STATS_EN
  logic [3:0]    hit_count, miss_count;
`endif

  always #5 CLK = ~CLK;

  cache_refill_controller #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OFFSET    (2)
`ifdef CACHE_STATS_EN
    ,
    .STAT_WIDTH(4)
`endif
  ) dut (
    .CLK           (CLK),
    .rst_n         (rst_n),
    .cpu_rd        (cpu_rd),
    .cpu_wr        (cpu_wr),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_stall     (cpu_stall),
    .cache_miss    (cache_miss),
    .cache_addr    (cache_addr),
    .cache_mem_rd  (cache_mem_rd),
    .cache_mem_wr  (cache_mem_wr),
    .cache_block_wr(cache_block_wr),
    .cache_in0     (cache_in0),
    .cache_in1     (cache_in1),
    .cache_in2     (cache_in2),
    .cache_in3     (cache_in3),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  // Cache model: one resident bit per 4-word block, set by a refill.
  logic [255:0] resident = '0;
  assign cache_miss = ~resident[cache_addr[AW-1:2]];
  always @(posedge CLK) if (cache_block_wr) resident[cache_addr[AW-1:2]] <= 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int blk_pulses = 0;
  int cwr_pulses = 0;
  always @(posedge CLK) begin
    if (cache_block_wr) blk_pulses++;
    if (cache_mem_wr) cwr_pulses++;
  end

  logic [127:0] exp_blk[$];
  logic [41:0]  exp_wr[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (cache_block_wr) begin
      if (exp_blk.size() == 0) chk("unexpected_refill", 128'(cache_block_wr), 128'd0);
      else chk("refill_block", {cache_in3, cache_in2, cache_in1, cache_in0}, exp_blk.pop_front());
    end
    if (mem_wr_req && mem_ack) begin
      if (exp_wr.size() == 0) chk("unexpected_write", 128'(mem_wr_req), 128'd0);
      else chk("write_addr_data", {mem_addr, mem_wdata}, exp_wr.pop_front());
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] base, input int ack_dly,
                       input int g0, input int g1, input int g2);
    int gaps[3];
    gaps = '{g0, g1, g2};
    cpu_rd = 1'b1;
    cpu_addr = a;
    #1;
    chk("miss_stall", cpu_stall, 1);
    exp_blk.push_back({base + 32'd3, base + 32'd2, base + 32'd1, base});
    step();
    chk("rd_req", mem_rd_req, 1);
    chk("rd_addr_aligned", mem_addr, {a[AW-1:2], 2'b00});
    repeat (ack_dly) step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rd_req_drop", mem_rd_req, 0);
    for (int k = 0; k < 4; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + DW'(k);
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (k < 3) begin
        for (int g = 0; g < gaps[k]; g++) begin
          chk("no_early_refill", cache_block_wr, 0);
          step();
        end
        chk("no_early_refill", cache_block_wr, 0);
      end
    end
    chk("refill_strobe", cache_block_wr, 1);
    chk("refill_stall", cpu_stall, 1);
    step();
    chk("hit_after_refill", cache_mem_rd, 1);
    chk("stall_released", cpu_stall, 0);
    chk("strobe_single", cache_block_wr, 0);
    cpu_rd = 1'b0;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input int ack_dly,
                       input logic exp_hit);
    cpu_wr = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    #1;
    chk("wr_stall", cpu_stall, 1);
    exp_wr.push_back({a, d});
    step();
    for (int i = 0; i < ack_dly; i++) begin
      chk("wr_req_held", mem_wr_req, 1);
      chk("wr_no_early_cwr", cache_mem_wr, 0);
      chk("wr_stall_held", cpu_stall, 1);
      step();
    end
    mem_ack = 1'b1;
    #1;
    chk("wr_req_at_ack", mem_wr_req, 1);
    chk("cache_wr_at_ack", cache_mem_wr, exp_hit);
    chk("wr_ack_nostall", cpu_stall, 0);
    step();
    mem_ack = 1'b0;
    cpu_wr = 1'b0;
    #1;
    chk("wr_req_drop", mem_wr_req, 0);
    chk("mem_addr_idle", mem_addr, 0);
    chk("mem_wdata_idle", mem_wdata, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    step();
    step();
    chk("rst_rd_req", mem_rd_req, 0);
    chk("rst_wr_req", mem_wr_req, 0);
    chk("rst_block_wr", cache_block_wr, 0);
    chk("rst_cache_in", {cache_in3, cache_in2, cache_in1, cache_in0}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_stall", cpu_stall, 0);
    rst_n = 1'b1;
    step();

    // Read miss then hit, memory ack after two waiting cycles.
    fetch(10'h045, 32'hA0, 2, 0, 0, 0);
    step();
    // Write hit on the resident line, ack in the third request cycle.
    store(10'h046, 32'hDEADBEEF, 2, 1'b1);
    step();
    // Write miss: no allocate.
    store(10'h300, 32'h12345678, 0, 1'b0);
    chk("cache_wr_count", cwr_pulses, 1);
    chk("refill_count_a", blk_pulses, 1);

    // Stray ack and beat while idle must be ignored.
    mem_ack = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h55;
    step();
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    chk("stray_beat_ignored", cache_in0, 32'hA0);
    chk("stray_ack_rd", mem_rd_req, 0);
    chk("stray_ack_wr", mem_wr_req, 0);

    // Beat gaps of 0, 3 and 1 cycles.
    fetch(10'h123, 32'hB0, 0, 0, 3, 1);
    chk("refill_count_b", blk_pulses, 2);

    // Reset after two beats of a fetch.
    step();
    cpu_rd = 1'b1;
    cpu_addr = 10'h210;
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hC0;
    step();
    mem_rdata = 32'hC1;
    step();
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    cpu_rd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_rd_req", mem_rd_req, 0);
    chk("abort_cache_in", {cache_in1, cache_in0}, 0);
    chk("abort_block_wr", cache_block_wr, 0);
    chk("abort_mem_addr", mem_addr, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("refill_count_c", blk_pulses, 2);
    fetch(10'h210, 32'hD0, 1, 0, 0, 0);
    chk("refill_count_d", blk_pulses, 3);

`ifdef CACHE_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fetch(10'h080, 32'hE0, 0, 0, 0, 0);
    cpu_rd = 1'b1;
    cpu_addr = 10'h081;
    repeat (20) step();
    cpu_rd = 1'b0;
    step();
    chk("hit_count_sat", hit_count, 15);
    chk("miss_count", miss_count, 1);
`endif

    step();
    chk("scoreboard_drained", exp_blk.size() + exp_wr.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
